// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack controller: core command codes, RAM port ops and FSM states.
package stack_ctrl_pkg;

  localparam int unsigned RAM_OP_LEN = 2;

  typedef enum logic [2:0] {
    STK_PUSH  = 3'd0,
    STK_POP   = 3'd1,
    STK_CALL  = 3'd2,
    STK_RET   = 3'd3,
    STK_SETSP = 3'd4
  } stk_cmd_e;

  typedef enum logic [RAM_OP_LEN-1:0] {
    OP_RAM_NOP     = 2'd0,
    OP_RAM_WR_BYTE = 2'd1,
    OP_RAM_WR_BIT  = 2'd2,
    OP_RAM_RD_BIT  = 2'd3
  } ram_op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PUSH_W,
    ST_CALL_LO,
    ST_CALL_HI,
    ST_POP_RD,
    ST_POP_CAP,
    ST_RET_HI,
    ST_RET_LO,
    ST_RET_CAP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/stack_ctrl.sv
// Stack controller: owns SP and turns PUSH/POP/CALL/RET/SETSP into internal-RAM byte ops.
// Optional wrap flags enabled by defining STACK_GUARD_EN.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [7:0]  SP_RESET = 8'h07,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  input  logic [2:0]            i_cmd,
  input  logic [7:0]            i_data,
  input  logic [15:0]           i_pc,
  output logic                  o_ready,
  output logic                  o_done,
  output logic [7:0]            o_data,
  output logic [15:0]           o_pc,
  output logic [ADDR_W-1:0]     o_sp,
  output logic [ADDR_W-1:0]     o_ram_addr,
  output logic [7:0]            o_ram_wr_byte,
  output logic [RAM_OP_LEN-1:0] o_ram_op,
  input  logic [7:0]            i_ram_byte,
  output logic                  o_ovf,
  output logic                  o_unf
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wr_q, wr_d;
  ram_op_e             op_q, op_d;
  logic [7:0]          data_q, data_d;
  logic [15:0]         pc_q, pc_d;
  logic [7:0]          pc_hi_q, pc_hi_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                accept;

  assign accept = i_req && ready_q;

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    op_d    = OP_RAM_NOP;
    data_d  = data_q;
    pc_d    = pc_q;
    pc_hi_d = pc_hi_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          case (stk_cmd_e'(i_cmd))
            STK_PUSH: begin
              sp_d    = sp_q + 1'b1;
              addr_d  = sp_q + 1'b1;
              wr_d    = i_data;
              op_d    = OP_RAM_WR_BYTE;
              state_d = ST_PUSH_W;
            end
            STK_POP: begin
              addr_d  = sp_q;
              state_d = ST_POP_RD;
            end
            STK_CALL: begin
              sp_d    = sp_q + 1'b1;
              addr_d  = sp_q + 1'b1;
              wr_d    = i_pc[7:0];
              pc_hi_d = i_pc[15:8];
              op_d    = OP_RAM_WR_BYTE;
              state_d = ST_CALL_LO;
            end
            STK_RET: begin
              addr_d  = sp_q;
              state_d = ST_RET_HI;
            end
            // SETSP shares the one-cycle wait of PUSH so o_done lands one edge after accept.
            STK_SETSP: begin
              sp_d    = ADDR_W'(i_data);
              state_d = ST_PUSH_W;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_PUSH_W:  state_d = ST_DONE;
      ST_CALL_LO: begin
        sp_d    = sp_q + 1'b1;
        addr_d  = sp_q + 1'b1;
        wr_d    = pc_hi_q;
        op_d    = OP_RAM_WR_BYTE;
        state_d = ST_CALL_HI;
      end
      ST_CALL_HI: state_d = ST_DONE;
      ST_POP_RD:  state_d = ST_POP_CAP;
      ST_POP_CAP: begin
        data_d  = i_ram_byte;
        sp_d    = sp_q - 1'b1;
        state_d = ST_DONE;
      end
      ST_RET_HI: begin
        addr_d  = sp_q - 1'b1;
        state_d = ST_RET_LO;
      end
      ST_RET_LO: begin
        pc_d[15:8] = i_ram_byte;
        state_d    = ST_RET_CAP;
      end
      ST_RET_CAP: begin
        pc_d[7:0] = i_ram_byte;
        sp_d      = sp_q - ADDR_W'(2);
        state_d   = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      sp_q    <= ADDR_W'(SP_RESET);
      addr_q  <= '0;
      wr_q    <= '0;
      op_q    <= OP_RAM_NOP;
      data_q  <= '0;
      pc_q    <= '0;
      pc_hi_q <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      op_q    <= op_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
      pc_hi_q <= pc_hi_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

`ifdef STACK_GUARD_EN
  logic ovf_q, unf_q;
  logic inc, ovf_set, unf_set, guard_clr;

  always_comb begin
    inc       = (accept && ((i_cmd == STK_PUSH) || (i_cmd == STK_CALL))) ||
                (state_q == ST_CALL_LO);
    ovf_set   = inc && (sp_q == '1);
    unf_set   = ((state_q == ST_POP_CAP) && (sp_q == '0)) ||
                ((state_q == ST_RET_CAP) && (sp_q < ADDR_W'(2)));
    guard_clr = accept && (i_cmd == STK_SETSP);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (guard_clr) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

  assign o_ovf = ovf_q;
  assign o_unf = unf_q;
`else
  assign o_ovf = 1'b0;
  assign o_unf = 1'b0;
`endif

  assign o_ready       = ready_q;
  assign o_done        = done_q;
  assign o_data        = data_q;
  assign o_pc          = pc_q;
  assign o_sp          = sp_q;
  assign o_ram_addr    = addr_q;
  assign o_ram_wr_byte = wr_q;
  assign o_ram_op      = op_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a behavioural internal RAM (write on edge, registered read).
module tb_stack_ctrl;

  localparam logic [2:0] C_PUSH  = 3'd0;
  localparam logic [2:0] C_POP   = 3'd1;
  localparam logic [2:0] C_CALL  = 3'd2;
  localparam logic [2:0] C_RET   = 3'd3;
  localparam logic [2:0] C_SETSP = 3'd4;
  localparam logic [1:0] OP_NOP  = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
`ifdef STACK_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [2:0]  cmd;
  logic [7:0]  din;
  logic [15:0] pc_in;
  logic        ready, done, ovf, unf;
  logic [7:0]  dout, sp, ram_addr, ram_wr, ram_byte;
  logic [15:0] pc_out;
  logic [1:0]  ram_op;

  logic [7:0]  mem [256];
  int          wr_count = 0;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.SP_RESET(8'h07), .ADDR_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_cmd(cmd), .i_data(din), .i_pc(pc_in),
    .o_ready(ready), .o_done(done), .o_data(dout), .o_pc(pc_out), .o_sp(sp),
    .o_ram_addr(ram_addr), .o_ram_wr_byte(ram_wr), .o_ram_op(ram_op), .i_ram_byte(ram_byte),
    .o_ovf(ovf), .o_unf(unf)
  );

  always @(posedge clk) begin
    if (ram_op == OP_WR) begin
      mem[ram_addr] <= ram_wr;
      wr_count      <= wr_count + 1;
    end
    ram_byte <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command, then wait (bounded) for o_done and check its latency in edges after accept.
  task automatic cmd_go(input logic [2:0] c, input logic [7:0] d, input logic [15:0] p,
                        input int lat, input int writes, input string tag);
    int waited;
    int wr0;
    @(negedge clk);
    req = 1'b1; cmd = c; din = d; pc_in = p;
    wr0 = wr_count;
    @(negedge clk);
    req = 1'b0;
    check({tag, "_busy"}, {31'd0, ready}, 32'd0);
    check({tag, "_op0"}, {30'd0, ram_op}, (writes > 0) ? {30'd0, OP_WR} : {30'd0, OP_NOP});
    waited = 0;
    while (done !== 1'b1 && waited < lat + 4) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_lat"}, waited, lat);
    check({tag, "_ready"}, {31'd0, ready}, 32'd1);
    check({tag, "_writes"}, wr_count - wr0, writes);
    check({tag, "_opnop"}, {30'd0, ram_op}, {30'd0, OP_NOP});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; cmd = '0; din = '0; pc_in = '0;
    repeat (3) @(negedge clk);
    check("rst_sp", sp, 32'h07);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", dout, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_addr", ram_addr, 32'd0);
    check("rst_wr", ram_wr, 32'd0);
    check("rst_op", {30'd0, ram_op}, {30'd0, OP_NOP});
    check("rst_flags", {30'd0, ovf, unf}, 32'd0);
    rst_n = 1'b1;

    cmd_go(C_PUSH, 8'hA5, 16'h0, 1, 1, "push_a5");
    check("push_a5_sp", sp, 32'h08);
    check("push_a5_mem", mem[8'h08], 32'hA5);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);

    cmd_go(C_POP, 8'h00, 16'h0, 2, 0, "pop_a5");
    check("pop_a5_data", dout, 32'hA5);
    check("pop_a5_sp", sp, 32'h07);

    cmd_go(C_PUSH, 8'h11, 16'h0, 1, 1, "push_11");
    cmd_go(C_PUSH, 8'h22, 16'h0, 1, 1, "push_22");
    check("push2_sp", sp, 32'h09);
    cmd_go(C_POP, 8'h00, 16'h0, 2, 0, "pop_22");
    check("pop_22_data", dout, 32'h22);
    cmd_go(C_POP, 8'h00, 16'h0, 2, 0, "pop_11");
    check("pop_11_data", dout, 32'h11);
    check("pop_11_sp", sp, 32'h07);

    cmd_go(C_CALL, 8'h00, 16'h1234, 2, 2, "call");
    check("call_lo", mem[8'h08], 32'h34);
    check("call_hi", mem[8'h09], 32'h12);
    check("call_sp", sp, 32'h09);
    cmd_go(C_RET, 8'h00, 16'h0, 3, 0, "ret");
    check("ret_pc", pc_out, 32'h1234);
    check("ret_sp", sp, 32'h07);
    check("ret_data_held", dout, 32'h11);

    cmd_go(C_SETSP, 8'hFF, 16'h0, 1, 0, "setsp_ff");
    check("setsp_ff_sp", sp, 32'hFF);
    cmd_go(C_PUSH, 8'h5A, 16'h0, 1, 1, "push_wrap");
    check("push_wrap_mem", mem[8'h00], 32'h5A);
    check("push_wrap_sp", sp, 32'h00);
    check("push_wrap_ovf", {31'd0, ovf}, {31'd0, GUARD});
    check("push_wrap_unf", {31'd0, unf}, 32'd0);
    cmd_go(C_POP, 8'h00, 16'h0, 2, 0, "pop_wrap");
    check("pop_wrap_data", dout, 32'h5A);
    check("pop_wrap_sp", sp, 32'hFF);
    check("pop_wrap_unf", {31'd0, unf}, {31'd0, GUARD});
    check("ovf_sticky", {31'd0, ovf}, {31'd0, GUARD});
    cmd_go(C_SETSP, 8'h07, 16'h0, 1, 0, "setsp_07");
    check("setsp_clr_flags", {30'd0, ovf, unf}, 32'd0);

    // Reset while the high return byte is being presented to the RAM.
    @(negedge clk);
    req = 1'b1; cmd = C_CALL; pc_in = 16'hBEEF;
    @(negedge clk);
    req = 1'b0;
    check("rc_lo_addr", ram_addr, 32'h08);
    @(negedge clk);
    check("rc_hi_addr", ram_addr, 32'h09);
    check("rc_hi_op", {30'd0, ram_op}, {30'd0, OP_WR});
    rst_n = 1'b0;
    #1;
    check("rc_async_op", {30'd0, ram_op}, {30'd0, OP_NOP});
    check("rc_async_sp", sp, 32'h07);
    @(negedge clk);
    rst_n = 1'b1;
    check("rc_mem09", mem[8'h09], 32'h12);
    check("rc_mem08", mem[8'h08], 32'hEF);
    check("rc_ready", {31'd0, ready}, 32'd1);
    check("rc_done", {31'd0, done}, 32'd0);

    // Request held high across a POP: the follow-on POP is taken only on the o_done cycle edge.
    cmd_go(C_PUSH, 8'h77, 16'h0, 1, 1, "push_77");
    cmd_go(C_PUSH, 8'h66, 16'h0, 1, 1, "push_66");
    @(negedge clk);
    req = 1'b1; cmd = C_POP;
    @(negedge clk);
    check("hold_t0_ready", {31'd0, ready}, 32'd0);
    @(negedge clk);
    check("hold_t1_ready", {31'd0, ready}, 32'd0);
    check("hold_t1_sp", sp, 32'h09);
    @(negedge clk);
    check("hold_t2_done", {31'd0, done}, 32'd1);
    check("hold_t2_data", dout, 32'h66);
    check("hold_t2_sp", sp, 32'h08);
    @(negedge clk);
    req = 1'b0;
    check("hold_t3_ready", {31'd0, ready}, 32'd0);
    check("hold_t3_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("hold_t4_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("hold_t5_done", {31'd0, done}, 32'd1);
    check("hold_t5_data", dout, 32'h77);
    check("hold_t5_sp", sp, 32'h07);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
